// File: rtl/semaforo_nway.sv
// ============================================================================
// semaforo_nway : N-approach demand-actuated traffic-light controller with
//                 min/max green, yellow, all-red clearance and parade hold.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module semaforo_nway #(
  parameter int N_APPR      = 4,
  parameter int APPR_W      = 2,
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 10,
  parameter int T_MAX_GREEN = 60,
  parameter int T_YELLOW    = 20,
  parameter int T_ALLRED    = 3,
  parameter int PARADE_APPR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPR-1:0]     sense,
  input  logic                  P,
  input  logic                  R,
  output logic [2*N_APPR-1:0]   lights,
  output logic [APPR_W-1:0]     cur_appr,
  output logic                  parade_active,
  output logic                  green_start
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;
  localparam logic [1:0] S_PARADE = 2'd3;

  localparam logic [CNT_W-1:0]  c_MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0]  c_MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0]  c_Y_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0]  c_AR_LAST  = CNT_W'((T_ALLRED == 0) ? 0 : T_ALLRED - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [APPR_W-1:0] c_PARADE   = APPR_W'(PARADE_APPR);

  logic [1:0]        state_q, state_d;
  logic [APPR_W-1:0] appr_q, appr_d;
  logic [APPR_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              go_parade_q, go_parade_d;
  logic              preq_q, preq_d;

  logic [2*N_APPR-1:0] w_rot;
  logic                w_other_dem;
  logic                w_own_dem;
  logic                w_green_exit;
  logic [APPR_W-1:0]   w_next_appr;

  // Bit k of w_rot is the sensor of approach (cur + k) mod N_APPR.
  assign w_rot        = {sense, sense} >> appr_q;
  assign w_own_dem    = w_rot[0];
  assign w_other_dem  = |w_rot[N_APPR-1:1];
  assign w_green_exit = (cnt_q >= c_MIN_LAST) &&
                        (preq_q || (w_other_dem && (!w_own_dem || cnt_q >= c_MAX_LAST)));

  // Walk downwards so the nearest requesting approach is the last one written.
  always_comb begin
    int tmp;
    w_next_appr = appr_q;
    for (int k = N_APPR - 1; k >= 1; k--) begin
      tmp = int'(appr_q) + k;
      if (tmp >= N_APPR) tmp = tmp - N_APPR;
      if (w_rot[k]) w_next_appr = APPR_W'(tmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_GREEN;
      appr_q      <= '0;
      dest_q      <= '0;
      cnt_q       <= '0;
      go_parade_q <= 1'b0;
      preq_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      appr_q      <= appr_d;
      dest_q      <= dest_d;
      cnt_q       <= cnt_d;
      go_parade_q <= go_parade_d;
      preq_q      <= preq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    appr_d      = appr_q;
    dest_d      = dest_q;
    go_parade_d = go_parade_q;
    preq_d      = P ? 1'b1 : (R ? 1'b0 : preq_q);

    case (state_q)
      S_GREEN: begin
        if (w_green_exit) begin
          if (preq_q && (appr_q == c_PARADE)) begin
            state_d = S_PARADE;
          end else if (preq_q) begin
            dest_d      = c_PARADE;
            go_parade_d = 1'b1;
            state_d     = S_YELLOW;
          end else begin
            dest_d  = w_next_appr;
            state_d = S_YELLOW;
          end
        end
      end
      S_YELLOW: begin
        if (cnt_q == c_Y_LAST) begin
          if (T_ALLRED != 0) begin
            state_d = S_ALLRED;
          end else begin
            go_parade_d = 1'b0;
            if (go_parade_q && preq_q) begin
              state_d = S_PARADE;
              appr_d  = c_PARADE;
            end else begin
              state_d = S_GREEN;
              appr_d  = dest_q;
            end
          end
        end
      end
      S_ALLRED: begin
        if (cnt_q >= c_AR_LAST) begin
          go_parade_d = 1'b0;
          if (go_parade_q && preq_q) begin
            state_d = S_PARADE;
            appr_d  = c_PARADE;
          end else begin
            state_d = S_GREEN;
            appr_d  = dest_q;
          end
        end
      end
      S_PARADE: begin
        appr_d = c_PARADE;
        if (!preq_q) state_d = S_GREEN;
      end
      default: begin
        state_d     = S_GREEN;
        appr_d      = '0;
        dest_d      = '0;
        go_parade_d = 1'b0;
        preq_d      = 1'b0;
      end
    endcase

    if ((state_d != state_q) || (appr_d != appr_q)) begin
      cnt_d = '0;
    end else if (cnt_q == c_CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    lights        = '0;
    cur_appr      = appr_q;
    parade_active = (state_q == S_PARADE);
    green_start   = (state_q == S_GREEN) && (cnt_q == '0);
    for (int j = 0; j < N_APPR; j++) begin
      if (APPR_W'(j) == appr_q) begin
        case (state_q)
          S_GREEN:  lights[2*j +: 2] = 2'b10;
          S_YELLOW: lights[2*j +: 2] = 2'b01;
          default:  lights[2*j +: 2] = 2'b00;
        endcase
      end
      if ((state_q == S_PARADE) && (j == PARADE_APPR)) lights[2*j +: 2] = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_semaforo_nway.sv
// ============================================================================
// tb_semaforo_nway : scoreboard bench for semaforo_nway (default build plus a
//                    build without all-red clearance).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_semaforo_nway;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sense, sense_b;
  logic       P, R;

  logic [7:0] lights_a, lights_b;
  logic [1:0] appr_a, appr_b;
  logic       pa_a, pa_b, gs_a, gs_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         which;
    logic [7:0] l;
    logic [1:0] a;
    logic       pa;
    logic       gs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  semaforo_nway u_dut_a (
    .clk(clk), .rst(rst), .sense(sense), .P(P), .R(R),
    .lights(lights_a), .cur_appr(appr_a), .parade_active(pa_a), .green_start(gs_a)
  );

  semaforo_nway #(.T_ALLRED(0)) u_dut_b (
    .clk(clk), .rst(rst), .sense(sense_b), .P(1'b0), .R(1'b0),
    .lights(lights_b), .cur_appr(appr_b), .parade_active(pa_b), .green_start(gs_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lamp(input int a, input logic [1:0] code);
    logic [7:0] v;
    v = '0;
    v[2*a +: 2] = code;
    return v;
  endfunction

  // Expected values describe the outputs right after the next rising edge.
  task automatic tick(input bit w, input logic [7:0] l, input logic [1:0] a,
                      input logic pa, input logic gs);
    exp_t e;
    @(posedge clk);
    #1;
    e.which = w; e.l = l; e.a = a; e.pa = pa; e.gs = gs;
    sb.push_back(e);
  endtask

  task automatic green(input bit w, input int a, input int n, input bit first);
    for (int i = 0; i < n; i++) tick(w, lamp(a, 2'b10), 2'(a), 1'b0, first && (i == 0));
  endtask

  task automatic yellow(input bit w, input int a, input int n);
    for (int i = 0; i < n; i++) tick(w, lamp(a, 2'b01), 2'(a), 1'b0, 1'b0);
  endtask

  task automatic allred(input bit w, input int a, input int n);
    for (int i = 0; i < n; i++) tick(w, 8'h00, 2'(a), 1'b0, 1'b0);
  endtask

  task automatic parade(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, lamp(1, 2'b10), 2'd1, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.which) begin
        check_eq("a_lights", 32'(lights_a), 32'(e.l));
        check_eq("a_appr",   32'(appr_a),   32'(e.a));
        check_eq("a_parade", 32'(pa_a),     32'(e.pa));
        check_eq("a_gstart", 32'(gs_a),     32'(e.gs));
      end else begin
        check_eq("b_lights", 32'(lights_b), 32'(e.l));
        check_eq("b_appr",   32'(appr_b),   32'(e.a));
        check_eq("b_parade", 32'(pa_b),     32'(e.pa));
        check_eq("b_gstart", 32'(gs_b),     32'(e.gs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sense = 4'b0000; sense_b = 4'b0000; P = 1'b0; R = 1'b0;

    // Idle: approach 0 rests on green.
    tick(0, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    tick(0, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    green(0, 0, 100, 1'b0);

    // Demand on approach 2 only: approach 1 is skipped.
    rst = 1'b1; sense = 4'b0100;
    tick(0, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    green(0, 0, 9, 1'b0);
    yellow(0, 0, 20);
    allred(0, 0, 3);
    green(0, 2, 16, 1'b1);

    // Parade request from approach 2 goes through yellow/all-red.
    P = 1'b1;
    green(0, 2, 1, 1'b0);
    P = 1'b0;
    yellow(0, 2, 20);
    allred(0, 2, 3);
    parade(4);
    R = 1'b1;
    parade(1);
    R = 1'b0;
    green(0, 1, 3, 1'b1);

    // Max-out on approach 0, then gap-out on approach 3.
    rst = 1'b1; sense = 4'b1001;
    tick(0, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    green(0, 0, 59, 1'b0);
    yellow(0, 0, 20);
    sense = 4'b0001;
    allred(0, 0, 3);
    green(0, 3, 10, 1'b1);
    yellow(0, 3, 5);

    // P and R together set the request; reset mid-yellow discards it.
    P = 1'b1; R = 1'b1;
    yellow(0, 3, 1);
    P = 1'b0; R = 1'b0;
    yellow(0, 3, 2);
    rst = 1'b1; sense = 4'b0000;
    tick(0, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    green(0, 0, 15, 1'b0);

    P = 1'b1; R = 1'b1;
    green(0, 0, 1, 1'b0);
    P = 1'b0; R = 1'b0;
    yellow(0, 0, 20);
    allred(0, 0, 3);
    parade(3);
    R = 1'b1;
    parade(1);
    R = 1'b0;
    green(0, 1, 11, 1'b1);

    // Parade request while the parade approach is green: no yellow.
    P = 1'b1;
    green(0, 1, 1, 1'b0);
    P = 1'b0;
    parade(2);
    R = 1'b1;
    parade(1);
    R = 1'b0;
    green(0, 1, 1, 1'b1);

    // Build without all-red: yellow goes straight to the next green.
    rst = 1'b1; sense_b = 4'b0010;
    tick(1, lamp(0, 2'b10), 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    green(1, 0, 9, 1'b0);
    yellow(1, 0, 20);
    green(1, 1, 3, 1'b1);

    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
